thread_sched: RTL and testbench

- Barrel-thread scheduler for the 4-thread RV32I pipeline.
- Each cycle it picks which hardware thread fetches next. The choice is a registered thread ID that travels down the pipeline with the instruction.
- Tracks per-thread run state:
  - start/stop control,
  - timed parking for multi-cycle ops (loads, CSR),
  - halting on illegal instructions reported by decode.
- Sits in front of the fetch unit; drives the thread ID used by fetch and decode.

---
 rtl/thread_sched.sv | 181 ++++++++++++++++++
 tb/tb_thread_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/thread_sched.sv
// Barrel-thread scheduler: round-robin pick of the next fetching thread, per-thread run-state tracking.
// Latency: thread_id_o/thread_valid_o registered (1 cycle); state-derived outputs have no added latency.
// Backpressure: issue_en_i=0 freezes selection outputs and pointer; thread states and park counters keep running.
//
// Ports: clk/rst (async active-high); issue_en_i; thread_start_i/thread_stop_i per-thread pulses;
//        stall_req_i/stall_tid_i/stall_cycles_i park request; illegal_inst_i/illegal_tid_i halt request;
//        thread_id_o/thread_valid_o issue slot; thread_state_o (2 bits per thread); halted_o; all_idle_o.
// Optional macro THREAD_SCHED_PERF_EN adds perf_issue_o and perf_wait_o (32-bit counters per thread).
module thread_sched #(
    parameter int NTHREADS = 4,
    parameter int TID_W    = 2,
    parameter int WAIT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_en_i,
    input  logic [NTHREADS-1:0]   thread_start_i,
    input  logic [NTHREADS-1:0]   thread_stop_i,
    input  logic                  stall_req_i,
    input  logic [TID_W-1:0]      stall_tid_i,
    input  logic [WAIT_W-1:0]     stall_cycles_i,
    input  logic                  illegal_inst_i,
    input  logic [TID_W-1:0]      illegal_tid_i,
    output logic [TID_W-1:0]      thread_id_o,
    output logic                  thread_valid_o,
    output logic [2*NTHREADS-1:0] thread_state_o,
    output logic [NTHREADS-1:0]   halted_o,
    output logic                  all_idle_o
`ifdef THREAD_SCHED_PERF_EN
    ,
    output logic [32*NTHREADS-1:0] perf_issue_o,
    output logic [32*NTHREADS-1:0] perf_wait_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_HALT = 2'b11;

    logic [1:0]        r_state [NTHREADS];
    logic [WAIT_W-1:0] r_cnt   [NTHREADS];
    logic [TID_W-1:0]  r_tid;
    logic              r_valid;
    // r_ptr is where the next search begins (last winner + 1), so a fresh
    // start of every thread issues in order 0,1,2,...
    logic [TID_W-1:0]  r_ptr;

    logic [1:0]        w_state_nxt [NTHREADS];
    logic [WAIT_W-1:0] w_cnt_nxt   [NTHREADS];
    logic [NTHREADS-1:0] w_ill_hit;
    logic [NTHREADS-1:0] w_stall_hit;
    logic [NTHREADS-1:0] w_elig;
    logic              w_found;
    logic [TID_W-1:0]  w_winner;
    logic [TID_W-1:0]  w_ptr_nxt;

`ifdef THREAD_SCHED_PERF_EN
    logic [31:0] r_perf_issue [NTHREADS];
    logic [31:0] r_perf_wait  [NTHREADS];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTHREADS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_tid   <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else begin
            for (int i = 0; i < NTHREADS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            if (issue_en_i) begin
                if (w_found) begin
                    r_tid   <= w_winner;
                    r_valid <= 1'b1;
                    r_ptr   <= w_ptr_nxt;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    // Next-state: per-thread transitions with priority illegal > stop > stall > start
    always_comb begin
        w_ill_hit   = '0;
        w_stall_hit = '0;
        w_elig      = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            // Out-of-range tids never match any thread index.
            w_ill_hit[i]   = illegal_inst_i && (int'(illegal_tid_i) == i);
            w_stall_hit[i] = stall_req_i && (int'(stall_tid_i) == i);
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            if (w_ill_hit[i]) begin
                w_state_nxt[i] = ST_HALT;
                w_cnt_nxt[i]   = '0;
            end else if (thread_stop_i[i]) begin
                w_state_nxt[i] = ST_IDLE;
                w_cnt_nxt[i]   = '0;
            end else if (w_stall_hit[i] && r_state[i] == ST_RUN) begin
                w_state_nxt[i] = ST_WAIT;
                w_cnt_nxt[i]   = (stall_cycles_i == '0) ? WAIT_W'(1) : stall_cycles_i;
            end else if (thread_start_i[i] && (r_state[i] == ST_IDLE || r_state[i] == ST_HALT)) begin
                w_state_nxt[i] = ST_RUN;
            end else if (r_state[i] == ST_WAIT) begin
                w_cnt_nxt[i] = r_cnt[i] - WAIT_W'(1);
                if (r_cnt[i] <= WAIT_W'(1)) begin
                    w_state_nxt[i] = ST_RUN;
                end
            end
            w_elig[i] = (r_state[i] == ST_RUN) && !w_ill_hit[i] && !thread_stop_i[i] && !w_stall_hit[i];
        end

        // Round-robin: the first eligible thread at rotation offset k from r_ptr wins.
        w_found   = 1'b0;
        w_winner  = '0;
        w_ptr_nxt = '0;
        for (int k = 0; k < NTHREADS; k++) begin
            for (int i = 0; i < NTHREADS; i++) begin
                if (!w_found && w_elig[i] && (i == (int'(r_ptr) + k) % NTHREADS)) begin
                    w_found   = 1'b1;
                    w_winner  = TID_W'(i);
                    w_ptr_nxt = TID_W'((i + 1) % NTHREADS);
                end
            end
        end
    end

    // Outputs
    always_comb begin
        thread_id_o    = r_tid;
        thread_valid_o = r_valid;
        thread_state_o = '0;
        halted_o       = '0;
        all_idle_o     = 1'b1;
        for (int i = 0; i < NTHREADS; i++) begin
            thread_state_o[2*i +: 2] = r_state[i];
            halted_o[i] = (r_state[i] == ST_HALT);
            if (r_state[i] == ST_RUN || r_state[i] == ST_WAIT) begin
                all_idle_o = 1'b0;
            end
        end
`ifdef THREAD_SCHED_PERF_EN
        perf_issue_o = '0;
        perf_wait_o  = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            perf_issue_o[32*i +: 32] = r_perf_issue[i];
            perf_wait_o[32*i +: 32]  = r_perf_wait[i];
        end
`endif
    end

`ifdef THREAD_SCHED_PERF_EN
    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTHREADS; i++) begin
                r_perf_issue[i] <= '0;
                r_perf_wait[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NTHREADS; i++) begin
                if (issue_en_i && w_found && w_winner == TID_W'(i)) begin
                    r_perf_issue[i] <= r_perf_issue[i] + 32'd1;
                end
                if (r_state[i] == ST_WAIT) begin
                    r_perf_wait[i] <= r_perf_wait[i] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_thread_sched.sv
// Directed bench for thread_sched: expected issue slots are queued per step and checked after the edge.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: exercises issue_en_i=0 hold and asynchronous reset mid-WAIT.
module tb_thread_sched;

    logic       clk;
    logic       rst;
    logic       issue_en_i;
    logic [3:0] thread_start_i;
    logic [3:0] thread_stop_i;
    logic       stall_req_i;
    logic [1:0] stall_tid_i;
    logic [3:0] stall_cycles_i;
    logic       illegal_inst_i;
    logic [1:0] illegal_tid_i;
    logic [1:0] thread_id_o;
    logic       thread_valid_o;
    logic [7:0] thread_state_o;
    logic [3:0] halted_o;
    logic       all_idle_o;

    typedef struct packed {
        logic       v;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    thread_sched dut (
        .clk            (clk),
        .rst            (rst),
        .issue_en_i     (issue_en_i),
        .thread_start_i (thread_start_i),
        .thread_stop_i  (thread_stop_i),
        .stall_req_i    (stall_req_i),
        .stall_tid_i    (stall_tid_i),
        .stall_cycles_i (stall_cycles_i),
        .illegal_inst_i (illegal_inst_i),
        .illegal_tid_i  (illegal_tid_i),
        .thread_id_o    (thread_id_o),
        .thread_valid_o (thread_valid_o),
        .thread_state_o (thread_state_o),
        .halted_o       (halted_o),
        .all_idle_o     (all_idle_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive inputs, queue the expected issue slot, check after the edge.
    task automatic step(input logic [3:0] st, input logic [3:0] sp,
                        input logic sreq, input logic [1:0] stid, input logic [3:0] scyc,
                        input logic ill, input logic [1:0] itid, input logic en,
                        input logic ev, input logic [1:0] eid);
        exp_t e;
        thread_start_i = st;
        thread_stop_i  = sp;
        stall_req_i    = sreq;
        stall_tid_i    = stid;
        stall_cycles_i = scyc;
        illegal_inst_i = ill;
        illegal_tid_i  = itid;
        issue_en_i     = en;
        e.v  = ev;
        e.id = eid;
        sb.push_back(e);
        @(posedge clk);
        #1;
        thread_start_i = '0;
        thread_stop_i  = '0;
        stall_req_i    = 1'b0;
        illegal_inst_i = 1'b0;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("valid", 32'(thread_valid_o), 32'(e.v));
            chk("tid", 32'(thread_id_o), 32'(e.id));
        end
    endtask

    task automatic idle(input logic ev, input logic [1:0] eid);
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, ev, eid);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tid"},   32'(thread_id_o),    32'd0);
        chk({tag, "_valid"}, 32'(thread_valid_o), 32'd0);
        chk({tag, "_state"}, 32'(thread_state_o), 32'd0);
        chk({tag, "_halt"},  32'(halted_o),       32'd0);
        chk({tag, "_idle"},  32'(all_idle_o),     32'd1);
    endtask

    initial begin
        rst = 1'b1;
        issue_en_i = 1'b0;
        thread_start_i = '0;
        thread_stop_i = '0;
        stall_req_i = 1'b0;
        stall_tid_i = '0;
        stall_cycles_i = '0;
        illegal_inst_i = 1'b0;
        illegal_tid_i = '0;
        #1;
        chk_reset_vals("rst0");
        #11;
        rst = 1'b0;

        // All four threads start together: in-order issue from the next edge.
        step(4'b1111, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        chk("all_run_state", 32'(thread_state_o), 32'h55);
        chk("all_run_idle", 32'(all_idle_o), 32'd0);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd1);
        idle(1'b1, 2'd2);
        idle(1'b1, 2'd3);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd1);

        // Stop everything: no valid slot, thread_id_o holds.
        step(4'b0000, 4'b1111, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);
        chk("stop_idle", 32'(all_idle_o), 32'd1);
        chk("stop_state", 32'(thread_state_o), 32'd0);
        idle(1'b0, 2'd1);

        // Threads 0 and 2; park 2 for three cycles.
        step(4'b0101, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1);
        chk("t02_state", 32'(thread_state_o), 32'h11);
        idle(1'b1, 2'd2);
        step(4'b0000, 4'b0000, 1'b1, 2'd2, 4'd3, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0);
        chk("wait_c1", 32'(thread_state_o[5:4]), 32'd2);
        idle(1'b1, 2'd0);
        chk("wait_c2", 32'(thread_state_o[5:4]), 32'd2);
        idle(1'b1, 2'd0);
        chk("wait_c3", 32'(thread_state_o[5:4]), 32'd2);
        idle(1'b1, 2'd0);
        chk("wait_done", 32'(thread_state_o[5:4]), 32'd1);
        idle(1'b1, 2'd2);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd2);
        step(4'b0000, 4'b1111, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2);

        // Illegal and stall on thread 1 in the same cycle: illegal wins.
        step(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2);
        idle(1'b1, 2'd0);
        step(4'b0000, 4'b0000, 1'b1, 2'd1, 4'd2, 1'b1, 2'd1, 1'b1, 1'b1, 2'd0);
        chk("halt_vec", 32'(halted_o), 32'h2);
        chk("halt_state", 32'(thread_state_o[3:2]), 32'd3);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd0);
        chk("halt_keep", 32'(halted_o), 32'h2);
        step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0);
        chk("restart_halt", 32'(halted_o), 32'h0);
        chk("restart_state", 32'(thread_state_o[3:2]), 32'd1);
        idle(1'b1, 2'd1);
        idle(1'b1, 2'd0);
        step(4'b0000, 4'b1111, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        // An idle thread can be halted; HALT still counts as idle.
        step(4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd0);
        chk("halt_idle_vec", 32'(halted_o), 32'h4);
        chk("halt_idle_all", 32'(all_idle_o), 32'd1);
        step(4'b0000, 4'b0100, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        chk("unhalt_stop", 32'(halted_o), 32'h0);

        // Zero-length park on thread 3 lasts exactly one cycle.
        step(4'b1000, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        idle(1'b1, 2'd3);
        step(4'b0000, 4'b0000, 1'b1, 2'd3, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd3);
        chk("zpark_wait", 32'(thread_state_o[7:6]), 32'd2);
        idle(1'b0, 2'd3);
        chk("zpark_run", 32'(thread_state_o[7:6]), 32'd1);
        idle(1'b1, 2'd3);
        idle(1'b1, 2'd3);

        // issue_en_i low: slot holds while the park still happens.
        step(4'b0000, 4'b0000, 1'b1, 2'd3, 4'd2, 1'b0, 2'd0, 1'b0, 1'b1, 2'd3);
        chk("frz_wait", 32'(thread_state_o[7:6]), 32'd2);

        // Asynchronous reset between edges, mid-WAIT.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;

        // Pointer is back at 0 after reset.
        step(4'b0101, 4'b0000, 1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        idle(1'b1, 2'd0);
        idle(1'b1, 2'd2);
        idle(1'b1, 2'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
